// File: rtl/pseudo_rand_chk.sv
// Receive-side checker for the pseudo_rand Galois LFSR stream: tracks lock/fail and counts errors.
// Optional first-error capture registers are built when PSEUDO_RAND_CHK_CAPTURE_EN is defined.
module pseudo_rand_chk #(
  parameter int unsigned WIDTH     = 257,
  parameter int unsigned ERR_LIMIT = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 locked,
  output logic                 fail,
  output logic                 mismatch,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] first_err_idx,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_obs
);

  localparam int unsigned LFSR_W = (WIDTH <= 64) ? 64 : ((WIDTH <= 128) ? 128 : 257);
  localparam logic [7:0]  POLY_LO = (LFSR_W == 64) ? 8'b00011011 :
                                    ((LFSR_W == 128) ? 8'b10000111 : 8'b11000101);
  localparam logic [256:0] SEED_FULL =
    257'h0_7163e168_713d5431_6684e132_5cd84848_f3048b46_76874654_0c45f864_04e4684a;
  localparam logic [LFSR_W-1:0] SEED = SEED_FULL[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] POLY = LFSR_W'(POLY_LO);
  localparam int unsigned CONS_W = $clog2(ERR_LIMIT + 1);
  localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(ERR_LIMIT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED, S_FAIL} state_e;

  state_e                state_q, state_d;
  logic [LFSR_W-1:0]     lfsr_q, lfsr_d, lfsr_step;
  logic [CONS_W-1:0]     consec_q, consec_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                  locked_q, locked_d;
  logic                  fail_q, fail_d;
  logic                  mismatch_q, mismatch_d;
  logic [WIDTH-1:0]      exp_word;
  logic                  hit;
  logic                  accept;

  assign exp_word  = lfsr_q[WIDTH-1:0];
  assign hit       = (in_data == exp_word);
  assign accept    = in_valid && !start && (state_q != S_IDLE);
  assign lfsr_step = {lfsr_q[LFSR_W-2:0], 1'b0} ^ (lfsr_q[LFSR_W-1] ? POLY : '0);

  // Next-state, counter and status logic; start overrides everything.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    consec_d   = consec_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    mismatch_d = 1'b0;
    if (start) begin
      state_d    = S_ACQ;
      lfsr_d     = SEED;
      consec_d   = '0;
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (accept) begin
      lfsr_d     = lfsr_step;
      mismatch_d = !hit;
      if (word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
      if (hit) begin
        consec_d = '0;
        if (state_q == S_ACQ) state_d = S_LOCKED;
      end else begin
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        if (consec_q != CONS_MAX) consec_d = consec_q + CONS_W'(1);
        if (consec_d == CONS_MAX) state_d = S_FAIL;
      end
    end
    locked_d = (state_d == S_LOCKED);
    fail_d   = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      consec_q   <= '0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      consec_q   <= consec_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign locked   = locked_q;
  assign fail     = fail_q;
  assign mismatch = mismatch_q;
  assign word_cnt = word_cnt_q;
  assign err_cnt  = err_cnt_q;

`ifdef PSEUDO_RAND_CHK_CAPTURE_EN
  logic [CNT_WIDTH-1:0] cap_idx_q, cap_idx_d;
  logic [WIDTH-1:0]     cap_exp_q, cap_exp_d;
  logic [WIDTH-1:0]     cap_obs_q, cap_obs_d;

  // Load once on the first miscompare since start (err_cnt still zero).
  always_comb begin
    cap_idx_d = cap_idx_q;
    cap_exp_d = cap_exp_q;
    cap_obs_d = cap_obs_q;
    if (start) begin
      cap_idx_d = '0;
      cap_exp_d = '0;
      cap_obs_d = '0;
    end else if (accept && !hit && (err_cnt_q == '0)) begin
      cap_idx_d = word_cnt_q;
      cap_exp_d = exp_word;
      cap_obs_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_idx_q <= '0;
      cap_exp_q <= '0;
      cap_obs_q <= '0;
    end else begin
      cap_idx_q <= cap_idx_d;
      cap_exp_q <= cap_exp_d;
      cap_obs_q <= cap_obs_d;
    end
  end

  assign first_err_idx = cap_idx_q;
  assign first_err_exp = cap_exp_q;
  assign first_err_obs = cap_obs_q;
`else
  assign first_err_idx = '0;
  assign first_err_exp = '0;
  assign first_err_obs = '0;
`endif

endmodule

// File: tb/tb_pseudo_rand_chk.sv
// Scoreboard bench for pseudo_rand_chk: a 32-bit checker with 4-bit counters is modelled per cycle,
// and 100/257-bit checkers are fed from a bench-side generator model during a long random run.
module tb_pseudo_rand_chk;

  localparam logic [256:0] SEED_FULL =
    257'h0_7163e168_713d5431_6684e132_5cd84848_f3048b46_76874654_0c45f864_04e4684a;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [31:0]  d32 = '0;
  logic [99:0]  d100 = '0;
  logic [256:0] d257 = '0;

  logic a_locked, a_fail, a_mis;
  logic [3:0]  a_wc, a_ec, a_idx;
  logic [31:0] a_exp, a_obs;
  logic b_locked, b_fail, b_mis;
  logic [15:0] b_wc, b_ec, b_idx;
  logic [99:0] b_exp, b_obs;
  logic c_locked, c_fail, c_mis;
  logic [15:0] c_wc, c_ec, c_idx;
  logic [256:0] c_exp, c_obs;

  always #5 clk = ~clk;

  pseudo_rand_chk #(.WIDTH(32), .ERR_LIMIT(4), .CNT_WIDTH(4)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(d32),
    .locked(a_locked), .fail(a_fail), .mismatch(a_mis), .word_cnt(a_wc), .err_cnt(a_ec),
    .first_err_idx(a_idx), .first_err_exp(a_exp), .first_err_obs(a_obs));

  pseudo_rand_chk #(.WIDTH(100), .ERR_LIMIT(4), .CNT_WIDTH(16)) u_dut100 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(d100),
    .locked(b_locked), .fail(b_fail), .mismatch(b_mis), .word_cnt(b_wc), .err_cnt(b_ec),
    .first_err_idx(b_idx), .first_err_exp(b_exp), .first_err_obs(b_obs));

  pseudo_rand_chk #(.WIDTH(257), .ERR_LIMIT(4), .CNT_WIDTH(16)) u_dut257 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(d257),
    .locked(c_locked), .fail(c_fail), .mismatch(c_mis), .word_cnt(c_wc), .err_cnt(c_ec),
    .first_err_idx(c_idx), .first_err_exp(c_exp), .first_err_obs(c_obs));

  typedef struct {
    logic        locked, fail, mis;
    logic [3:0]  wc, ec, idx;
    logic [31:0] exp, obs;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model state for the 32-bit checker and the two wide generators.
  int          m_st;  // 0 idle, 1 acq, 2 locked, 3 fail
  logic [256:0] m_lfsr, g100, g257;
  logic [3:0]  m_wc, m_ec, m_idx;
  logic [31:0] m_exp, m_obs;
  int          m_con;
  logic        m_mis;
  logic        wide_mis_seen;
  int          n_acc;

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [256:0] lmask(input int l);
    logic [256:0] m;
    m = '1;
    if (l < 257) m = (257'd1 << l) - 257'd1;
    return m;
  endfunction

  function automatic logic [256:0] step_l(input logic [256:0] v, input int l);
    logic [256:0] r;
    logic [7:0]   p;
    p = (l == 64) ? 8'h1b : ((l == 128) ? 8'h87 : 8'hc5);
    r = (v << 1) & lmask(l);
    if (v[l-1]) r = r ^ {249'd0, p};
    return r;
  endfunction

  function automatic logic [31:0] good32();
    return m_lfsr[31:0];
  endfunction

  task automatic model_reset();
    m_st = 0; m_lfsr = SEED_FULL & lmask(64); m_wc = '0; m_ec = '0; m_idx = '0;
    m_exp = '0; m_obs = '0; m_con = 0; m_mis = 1'b0;
    g100 = SEED_FULL & lmask(128); g257 = SEED_FULL;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_locked", 257'(a_locked), 257'(0));
    chk("rst_fail", 257'(a_fail), 257'(0));
    chk("rst_wc", 257'(a_wc), 257'(0));
    chk("rst_ec", 257'(a_ec), 257'(0));
    chk("rst_w257_locked", 257'(c_locked), 257'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic cyc(input logic st, input logic v, input logic [31:0] din);
    exp_t e;
    logic [31:0] ew;
    start = st; in_valid = v; d32 = din;
    d100 = g100[99:0]; d257 = g257;
    m_mis = 1'b0;
    if (st) begin
      m_lfsr = SEED_FULL & lmask(64); m_wc = '0; m_ec = '0; m_con = 0;
      m_idx = '0; m_exp = '0; m_obs = '0; m_st = 1;
    end else if (v && m_st != 0) begin
      ew = m_lfsr[31:0];
      m_mis = (din != ew);
      if (m_mis && m_ec == 4'd0) begin m_idx = m_wc; m_exp = ew; m_obs = din; end
      if (m_wc != 4'hf) m_wc = m_wc + 4'd1;
      if (m_mis) begin
        if (m_ec != 4'hf) m_ec = m_ec + 4'd1;
        if (m_con < 4) m_con++;
        if (m_con == 4) m_st = 3;
      end else begin
        m_con = 0;
        if (m_st == 1) m_st = 2;
      end
      m_lfsr = step_l(m_lfsr, 64);
    end
    e.locked = (m_st == 2); e.fail = (m_st == 3); e.mis = m_mis;
    e.wc = m_wc; e.ec = m_ec;
`ifdef PSEUDO_RAND_CHK_CAPTURE_EN
    e.idx = m_idx; e.exp = m_exp; e.obs = m_obs;
`else
    e.idx = '0; e.exp = '0; e.obs = '0;
`endif
    exp_q.push_back(e);
    if (st) begin
      g100 = SEED_FULL & lmask(128); g257 = SEED_FULL; n_acc = 0;
    end else if (v) begin
      g100 = step_l(g100, 128); g257 = step_l(g257, 257); n_acc++;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("locked", 257'(a_locked), 257'(e.locked));
    chk("fail", 257'(a_fail), 257'(e.fail));
    chk("mismatch", 257'(a_mis), 257'(e.mis));
    chk("word_cnt", 257'(a_wc), 257'(e.wc));
    chk("err_cnt", 257'(a_ec), 257'(e.ec));
    chk("first_err_idx", 257'(a_idx), 257'(e.idx));
    chk("first_err_exp", 257'(a_exp), 257'(e.exp));
    chk("first_err_obs", 257'(a_obs), 257'(e.obs));
    if (b_mis || c_mis) wide_mis_seen = 1'b1;
  endtask

  initial begin
    wide_mis_seen = 1'b0;
    n_acc = 0;
    do_reset();

    // Valid words in IDLE are ignored.
    cyc(1'b0, 1'b1, 32'h04e4684a);
    chk("idle_wc", 257'(a_wc), 257'(0));

    // Clean acquisition with literal stream words.
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h04e4684a);
    chk("acq_locked", 257'(a_locked), 257'(1));
    cyc(1'b0, 1'b1, 32'h09c8d094);
    cyc(1'b0, 1'b1, 32'h1391a128);
    chk("acq_wc3", 257'(a_wc), 257'(3));
    chk("acq_ec0", 257'(a_ec), 257'(0));

    // Single corrupted word: one pulse, still locked.
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h04e4684a);
    cyc(1'b0, 1'b1, 32'hdeadbeef);
    chk("single_mis", 257'(a_mis), 257'(1));
    cyc(1'b0, 1'b1, good32());
    chk("single_mis_gone", 257'(a_mis), 257'(0));
    cyc(1'b0, 1'b1, good32());
    chk("single_ec1", 257'(a_ec), 257'(1));
    chk("single_locked", 257'(a_locked), 257'(1));
`ifdef PSEUDO_RAND_CHK_CAPTURE_EN
    chk("cap_idx", 257'(a_idx), 257'(1));
    chk("cap_exp", 257'(a_exp), 257'(32'h09c8d094));
    chk("cap_obs", 257'(a_obs), 257'(32'hdeadbeef));
`endif

    // ERR_LIMIT consecutive misses force sticky FAIL.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, ~good32());
    chk("pre_fail", 257'(a_fail), 257'(0));
    cyc(1'b0, 1'b1, ~good32());
    chk("fail_set", 257'(a_fail), 257'(1));
    chk("fail_unlocked", 257'(a_locked), 257'(0));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, good32());
    chk("fail_sticky", 257'(a_fail), 257'(1));

    // Word alongside start is ignored.
    cyc(1'b1, 1'b1, 32'h12345678);
    cyc(1'b0, 1'b1, 32'h04e4684a);
    chk("start_valid_locked", 257'(a_locked), 257'(1));
    chk("start_valid_ec", 257'(a_ec), 257'(0));

    // Counter saturation with 4-bit counters.
    cyc(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, ~good32());
    chk("sat_ec", 257'(a_ec), 257'(15));
    chk("sat_wc", 257'(a_wc), 257'(15));

    // Long random run with wide checkers and a mid-run reset.
    do_reset();
    cyc(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5000; i++) cyc(1'b0, 1'($urandom_range(0, 1)), good32());
    chk("rnd1_w100_locked", 257'(b_locked), 257'(1));
    chk("rnd1_w257_locked", 257'(c_locked), 257'(1));
    chk("rnd1_w257_wc", 257'(c_wc), 257'(n_acc));
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'($urandom_range(0, 1)), good32());
    chk("post_rst_w257_wc", 257'(c_wc), 257'(0));
    cyc(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5000; i++) cyc(1'b0, 1'($urandom_range(0, 1)), good32());
    chk("rnd2_w100_ec", 257'(b_ec), 257'(0));
    chk("rnd2_w257_ec", 257'(c_ec), 257'(0));
    chk("rnd2_w100_wc", 257'(b_wc), 257'(n_acc));
    chk("rnd2_w257_wc", 257'(c_wc), 257'(n_acc));
    chk("rnd2_w100_locked", 257'(b_locked), 257'(1));
    chk("rnd2_w257_locked", 257'(c_locked), 257'(1));
    chk("rnd2_wide_fail", 257'({b_fail, c_fail}), 257'(0));
    chk("rnd2_wide_mis_seen", 257'(wide_mis_seen), 257'(0));
    chk("rnd2_wide_cap_idx", 257'(b_idx | c_idx), 257'(0));
    chk("rnd2_wide_cap_data", 257'(b_exp | b_obs) | c_exp | c_obs, 257'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pseudo_rand_chk.md
# pseudo_rand_chk

Receive-side checker for the pseudo-random stream produced by `pseudo_rand`. It holds a local copy of the same Galois LFSR, seeded with the same constant, and advances it once per valid input word. Each incoming word is compared against the expected value, mismatches are counted, and the block reports lock/fail status. It sits at the far end of a link, memory path or datapath under test, opposite the generator.

## Interface
- `WIDTH`, 257: data word width, 1..257; LFSR width selected exactly as in the generator (≤64→64, ≤128→128, ≤257→257).
- `ERR_LIMIT`, 4: consecutive mismatches that force FAIL; ≥1.
- `CNT_WIDTH`, 16: width of word/error counters.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: reseed, clear counters, enter ACQ.
- `in_valid`  in  1  `in_data` carries the next stream word this cycle.
- `in_data`  in  WIDTH  observed word.
- `locked`  out  1  state is LOCKED.
- `fail`  out  1  state is FAIL (sticky).
- `mismatch`  out  1  one-cycle pulse per miscompared word.
- `word_cnt`  out  CNT_WIDTH  words checked since start, saturating.
- `err_cnt`  out  CNT_WIDTH  mismatched words since start, saturating.
- `first_err_idx`  out  CNT_WIDTH  `word_cnt` value of first mismatch.
- `first_err_exp`  out  WIDTH  expected word at first mismatch.
- `first_err_obs`  out  WIDTH  observed word at first mismatch.

## Operation
- Polynomial low byte: LFSR 64 → 8'b00011011, 128 → 8'b10000111, 257 → 8'b11000101; upper bits zero.
- SEED: 257'h0_7163e168_713d5431_6684e132_5cd84848_f3048b46_76874654_0c45f864_04e4684a, truncated to LFSR width.
- Step: `lfsr ← {lfsr[L-2:0],0} ^ (lfsr[L-1] ? POLY : 0)`. Expected word = `lfsr[WIDTH-1:0]`.
- States: IDLE, ACQ, LOCKED, FAIL.
  - IDLE (reset state): `in_valid` ignored; `start` → ACQ.
  - ACQ: valid match → LOCKED; valid mismatch → count, `consec++`; `consec == ERR_LIMIT` → FAIL.
  - LOCKED: match clears `consec`; mismatch counts and increments `consec`; `consec == ERR_LIMIT` → FAIL.
  - FAIL: sticky. The LFSR keeps advancing and counters keep updating; only `start` or reset leaves this state.
- `start` in any state: `lfsr ← SEED`, clear `word_cnt`, `err_cnt`, `consec` and capture regs → ACQ. A word presented with `in_valid` in the `start` cycle is ignored and does not advance the LFSR.
- The LFSR advances on every accepted valid word, match or not. This follows the non-stalling generator, so an isolated corrupted word does not break sync.
- Counters saturate at all-ones and never wrap. `consec` saturates at ERR_LIMIT.

## Timing
- All outputs are registered. Reset values: `locked=0`, `fail=0`, `mismatch=0`, all counters and capture outputs 0, state IDLE, `lfsr=SEED`.
- The word presented at cycle N updates `mismatch`, the counters, the state and `locked`/`fail`, all visible at cycle N+1.
- Back-to-back `in_valid` is supported at one word per clock. There is no backpressure.
- Reset asserted mid-stream returns to IDLE immediately. There is no automatic reacquisition.

## Configuration
- `PSEUDO_RAND_CHK_CAPTURE_EN` defined:
  - On the first mismatch after `start`, `first_err_idx`, `first_err_exp` and `first_err_obs` are loaded.
  - They hold until the next `start` or reset.
- Not defined: the capture registers are not built and the three capture outputs are tied to 0. All other behaviour is unchanged.

## Test plan
- WIDTH=32, reset, `start`, then feed 0x04e4684a, 0x09c8d094, 0x1391a128 on consecutive cycles -> `locked=1` one cycle after the first word; `word_cnt=3`, `err_cnt=0`, no `mismatch`.
- Locked stream with word 1 replaced by 0xDEADBEEF -> exactly one `mismatch` pulse; `err_cnt=1`, stays LOCKED. With CAPTURE_EN: idx=1, exp=0x09c8d094, obs=0xDEADBEEF.
- ERR_LIMIT=4, feed 4 consecutive wrong words after lock -> `fail=1` one cycle after the 4th; `locked=0`; good words afterward do not clear `fail`.
- `start` asserted together with `in_valid` -> that word is ignored; the next valid word 0x04e4684a matches.
- CNT_WIDTH=4, 20 corrupt words -> `err_cnt` saturates at 15 and `word_cnt` at 15.
- WIDTH=257 and WIDTH=100: loop a `pseudo_rand` instance into the checker for 10,000 cycles with `in_valid` toggling randomly, mid-run `reset_n` pulse, then `start` -> `err_cnt=0` throughout.
